// File: rtl/multicycle_controller.sv
// Main control FSM for the shared multicycle RV32I datapath (lw, sw, R/I-type ALU, beq, jal).
// Outputs are decoded from state. The exceptions depend on mem_ready, zero or op.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;  // unsupported opcode: drop it
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  logic w_op_legal;
  assign w_op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal_op = 1'b0;
    // Reset aborts whatever state is in flight, so nothing is written.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b01;
          imm_src    = (op == OP_JAL) ? 2'b11 : 2'b10;
          illegal_op = !w_op_legal;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table plus
// hand-written latency and illegal-opcode sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] op;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_op;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .illegal_op(illegal_op)
  );

  // Output vector: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //                 imm_src, alu_src_a, alu_src_b, alu_op, result_src, illegal_op}
  logic [16:0] w_out;
  assign w_out = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  imm_src, alu_src_a, alu_src_b, alu_op, result_src, illegal_op};

  localparam logic [16:0] E_RST    = 17'b0;
  localparam logic [16:0] E_F_RDY  = {6'b100110, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_F_WAIT = {6'b100000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_DEC    = {6'b000000, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC_J  = {6'b000000, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC_IL = {6'b000000, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_MA_LD  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MA_ST  = {6'b000000, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MRD    = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] E_MWR    = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_EXR    = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_EXI    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_AWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_BEQ_T  = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] E_BEQ_N  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] E_JAL    = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] IL = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [6:0] o, input logic z,
                     input logic rd, input logic [16:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for the next FETCH with ir_write, then counts cycles to the following one.
  task automatic measure(input string name, input logic [6:0] o,
                         input int exp_cycles, input int exp_ill);
    int n;
    int ill;
    bit found;
    op = o; zero = 1'b0; mem_ready = 1'b1; rst = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ir_write) found = 1;
    end
    check({name, "_sync"}, int'(found), 1);
    n = 0; ill = 0;
    do begin
      @(negedge clk);
      n++;
      ill += int'(illegal_op);
    end while (!ir_write && n < 20);
    check({name, "_cycles"}, n, exp_cycles);
    check({name, "_illegal_pulses"}, ill, exp_ill);
    $display("measure %s: cycles=%0d illegal_pulses=%0d", name, n, ill);
  endtask

  initial begin
    rst = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;

    // Reset held 3 cycles with mem_ready high
    repeat (3) add(1, LW, 0, 1, E_RST);
    // lw, zero-wait
    add(0, LW, 0, 1, E_F_RDY); add(0, LW, 0, 1, E_DEC); add(0, LW, 0, 1, E_MA_LD);
    add(0, LW, 0, 1, E_MRD);   add(0, LW, 0, 1, E_MWB);
    // sw with two wait cycles in MEMWRITE
    add(0, SW, 0, 1, E_F_RDY); add(0, SW, 0, 1, E_DEC); add(0, SW, 0, 1, E_MA_ST);
    add(0, SW, 0, 0, E_MWR);   add(0, SW, 0, 0, E_MWR); add(0, SW, 0, 1, E_MWR);
    // beq taken, then not taken
    add(0, BQ, 1, 1, E_F_RDY); add(0, BQ, 1, 1, E_DEC); add(0, BQ, 1, 1, E_BEQ_T);
    add(0, BQ, 0, 1, E_F_RDY); add(0, BQ, 0, 1, E_DEC); add(0, BQ, 0, 1, E_BEQ_N);
    // jal
    add(0, JL, 0, 1, E_F_RDY); add(0, JL, 0, 1, E_DEC_J); add(0, JL, 0, 1, E_JAL);
    add(0, JL, 0, 1, E_AWB);
    // R-type and I-type
    add(0, RT, 0, 1, E_F_RDY); add(0, RT, 0, 1, E_DEC); add(0, RT, 0, 1, E_EXR);
    add(0, RT, 0, 1, E_AWB);
    add(0, IT, 0, 1, E_F_RDY); add(0, IT, 0, 1, E_DEC); add(0, IT, 0, 1, E_EXI);
    add(0, IT, 0, 1, E_AWB);
    // Fetch wait then illegal opcode
    add(0, IL, 0, 0, E_F_WAIT); add(0, IL, 0, 1, E_F_RDY); add(0, IL, 0, 1, E_DEC_IL);
    // lw with reset during the MEMREAD wait
    add(0, LW, 0, 1, E_F_RDY); add(0, LW, 0, 1, E_DEC); add(0, LW, 0, 1, E_MA_LD);
    add(0, LW, 0, 0, E_MRD);   add(1, LW, 0, 0, E_RST);
    add(0, LW, 0, 0, E_F_WAIT); add(0, LW, 0, 1, E_F_RDY); add(0, LW, 0, 1, E_DEC);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      @(negedge clk);
      checks++;
      if (w_out !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d outputs: got %05h expected %05h", i, w_out, vecs[i].exp);
      end else begin
        $display("vec%0d rst=%0b op=%07b zero=%0b rdy=%0b out=%05h ok",
                 i, vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy, w_out);
      end
      checks++;
      if (reg_write && mem_write) begin
        failures++;
        $display("FAIL vec%0d write_exclusive: got reg_write=1 mem_write=1 expected not both", i);
      end
    end

    // Zero-wait latencies from FETCH entry to next FETCH entry
    measure("lw", LW, 5, 0);
    measure("sw", SW, 4, 0);
    measure("beq", BQ, 3, 0);
    measure("illegal", IL, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
